hsv_core_alu_issue: RTL
=======================

HSV_CORE_ALU_ISSUE -- requirements
Module: hsv_core_alu_issue

Interface
REQ-001 Parameter: DEPTH, 2, number of buffered alu_data_t entries (power of two, >=2).
REQ-002 Port: clk_core  input  1  core clock; all state updates on its rising edge.
REQ-003 Port: rst_core  input  1  reset; one clock domain, synchronous, active-high.
REQ-004 Port: in_data  input  $bits(alu_data_t)  ALU micro-op from decode/issue (hsv_core_pkg::alu_data_t).
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: alu_data  output  $bits(alu_data_t)  micro-op presented to hsv_core_alu.
REQ-008 Port: valid_o  output  1  alu_data is valid; drives the ALU valid_i.
REQ-009 Port: ready_i  input  1  ALU accepts alu_data; driven by the ALU ready_o.
REQ-010 Port: flush_req  input  1  pipeline flush request.
REQ-011 Port: flush_ack  output  1  flush complete; block is empty and idle.
REQ-012 Port: count  output  $clog2(DEPTH+1)  current number of buffered entries.

Function
REQ-013 Block SHALL be a DEPTH-entry FIFO (head/tail pointers plus occupancy counter) between decode and the ALU input handshake.
REQ-014 Transfer in: in_valid && in_ready on a rising edge SHALL write in_data at the tail, advance tail (mod DEPTH), count+1.
REQ-015 Transfer out: valid_o && ready_i on a rising edge SHALL retire the head, advance head (mod DEPTH), count-1.
REQ-016 Simultaneous in and out transfer SHALL leave count unchanged and advance both pointers.
REQ-017 in_ready SHALL be 1 only in state RUN with count < DEPTH; combinational from state and count only, never from ready_i.
REQ-018 valid_o SHALL be 1 only in state RUN with count > 0; registered-state derived, no combinational path from in_valid.
REQ-019 alu_data SHALL equal the head entry when valid_o=1 and all-zero when valid_o=0.
REQ-020 alu_data and valid_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-021 Latency: an entry written at edge N SHALL be visible on valid_o/alu_data after edge N (earliest ALU acceptance at edge N+1); no in-to-out bypass.
REQ-022 Entries SHALL leave in write order; entries SHALL never be dropped or duplicated outside a flush.
REQ-023 Full (count=DEPTH): in_ready=0, in_data ignored; a pop that cycle reopens in_ready next cycle.
REQ-024 Empty (count=0): valid_o=0, ready_i ignored, no pointer change.
REQ-025 FSM states: RUN, FLUSH.
REQ-026 RUN -> FLUSH on flush_req=1 at an edge; that edge SHALL clear count, head, tail; any in or out transfer at that edge SHALL be discarded.
REQ-027 In FLUSH: in_ready=0, valid_o=0, flush_ack=1.
REQ-028 FLUSH -> RUN on the first edge with flush_req=0; flush_ack SHALL drop in the same cycle RUN resumes.
REQ-029 flush_ack SHALL be 0 in RUN; flush_req in FLUSH keeps state FLUSH.
REQ-030 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 rst_core=1 at an edge SHALL force state RUN, head=tail=0, count=0; outputs next cycle: valid_o=0, in_ready=1, flush_ack=0, alu_data=0.
REQ-032 Reset SHALL override in-flight transfers and flush; FIFO storage contents need not be cleared.

Verification
REQ-033 Pass-through: after reset, ready_i=1, push one op (bitwise_select=ALU_BITWISE_AND, rs1=rs2=0x10) -> valid_o=1 next cycle with identical alu_data, count 1 -> 0 after accept.
REQ-034 Backpressure/full: ready_i=0, push ops rs1=0x1,0x2,0x3 (DEPTH=2) -> third not accepted (in_ready=0, count=2); ready_i=1 -> outputs 0x1, 0x2 in order, then 0x3 once re-pushed.
REQ-035 Stability: valid_o=1, ready_i=0 for 5 cycles -> alu_data and valid_o unchanged every cycle.
REQ-036 Simultaneous push/pop at count=1 -> count stays 1, order preserved (rs1=0xA then 0xB observed).
REQ-037 Flush: count=2, assert flush_req 3 cycles -> next cycle valid_o=0, in_ready=0, flush_ack=1, count=0; release -> flush_ack=0, in_ready=1, old entries never appear.
REQ-038 Reset mid-operation: count=2, rst_core=1 one cycle -> count=0, valid_o=0, in_ready=1; a fresh push of rs1=0x5A5A5A5A is the next output.

Source files
------------

// File: rtl/hsv_core_alu_issue.sv
// Issue buffer between decode and the ALU: a small FIFO with flush support.
// The ALU micro-op type lives in hsv_core_pkg, kept in this file so the block stands alone.

package hsv_core_pkg;
  typedef enum logic [1:0] {
    ALU_BITWISE_AND,
    ALU_BITWISE_OR,
    ALU_BITWISE_XOR,
    ALU_BITWISE_PASS
  } alu_bitwise_t;

  typedef struct packed {
    alu_bitwise_t bitwise_select;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    logic [4:0]   rd;
  } alu_data_t;
endpackage

module hsv_core_alu_issue #(
  parameter int DEPTH = 2
) (
  input  logic                                  clk_core,
  input  logic                                  rst_core,
  input  logic [$bits(hsv_core_pkg::alu_data_t)-1:0] in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [$bits(hsv_core_pkg::alu_data_t)-1:0] alu_data,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  input  logic                                  flush_req,
  output logic                                  flush_ack,
  output logic [$clog2(DEPTH+1)-1:0]            count
);

  localparam int W  = $bits(hsv_core_pkg::alu_data_t);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic push, pop;

  // Handshake outputs depend only on registered state, so neither side sees
  // a combinational path through this block.
  always_comb begin
    in_ready  = 1'b0;
    valid_o   = 1'b0;
    flush_ack = 1'b0;
    if (state_q == RUN) begin
      in_ready = (count_q < CW'(DEPTH));
      valid_o  = (count_q != '0);
    end else begin
      flush_ack = 1'b1;
    end
  end

  assign push     = in_valid && in_ready;
  assign pop      = valid_o && ready_i;
  assign alu_data = valid_o ? mem_q[head_q] : '0;
  assign count    = count_q;

  // A flush edge discards whatever transfer happened to coincide with it.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d = FLUSH;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          if (push) tail_d = tail_q + 1'b1;
          if (pop)  head_d = head_q + 1'b1;
          if (push && !pop)      count_d = count_q + 1'b1;
          else if (pop && !push) count_d = count_q - 1'b1;
        end
      end
      FLUSH: begin
        if (!flush_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only entries covered by count are ever presented.
  always_ff @(posedge clk_core) begin
    if (push && !flush_req && !rst_core) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule
